// File: rtl/exu_brupd_ctl.sv
// Branch-update queue between the resolving ALU and the IFU branch predictor.
// Full queue: plain updates are dropped, mispredicts replace the youngest entry.
module exu_brupd_ctl #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DCW   = 8
) (
  input  logic            clk,
  input  logic            rst_l,
  input  logic            freeze,
  input  logic            flush,
  input  logic            br_valid,
  input  logic [31:1]     br_pc,
  input  logic [31:1]     br_target,
  input  logic            br_ataken,
  input  logic            br_misp,
  input  logic [1:0]      br_hist,
  output logic            upd_valid,
  input  logic            upd_ready,
  output logic [31:1]     upd_pc,
  output logic [31:1]     upd_target,
  output logic            upd_ataken,
  output logic            upd_misp,
  output logic [1:0]      upd_hist,
  output logic            q_full,
  output logic [DCW-1:0]  drop_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  typedef struct packed {
    logic [31:1] pc;
    logic [31:1] target;
    logic        ataken;
    logic        misp;
    logic [1:0]  hist;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            empty;
  logic            full;
  logic            push_req;
  logic            pop;
  logic            push_ok;
  logic            overflow;
  logic            overwrite;
  logic [AW-1:0]   wr_idx;
  logic [AW-1:0]   ow_idx;
  entry_t          new_entry;
  entry_t          head;

  // Occupancy from registered pointers only
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign push_req  = br_valid & ~flush & ~freeze;
  assign pop       = ~empty & upd_ready;
  assign push_ok   = push_req & (~full | pop);
  assign overflow  = push_req & full & ~pop;
  assign overwrite = overflow & br_misp;

  assign wr_idx = wr_ptr[AW-1:0];
  assign ow_idx = AW'(wr_ptr[AW-1:0] - AW'(1));

  always_comb begin
    new_entry        = '0;
    new_entry.pc     = br_pc;
    new_entry.target = br_target;
    new_entry.ataken = br_ataken;
    new_entry.misp   = br_misp;
    new_entry.hist   = br_hist;
  end

  // Pointers and drop counter
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      drop_cnt <= '0;
    end else begin
      if (push_ok) wr_ptr <= PW'(wr_ptr + PW'(1));
      if (pop)     rd_ptr <= PW'(rd_ptr + PW'(1));
      if (overflow && (drop_cnt != {DCW{1'b1}})) drop_cnt <= DCW'(drop_cnt + DCW'(1));
    end
  end

  // Entry storage; a push-with-pop on a full queue reuses the slot being popped
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_ok)        mem[wr_idx] <= new_entry;
      else if (overwrite) mem[ow_idx] <= new_entry;
    end
  end

  assign head       = mem[rd_ptr[AW-1:0]];
  assign upd_valid  = ~empty;
  assign q_full     = full;
  assign upd_pc     = head.pc;
  assign upd_target = head.target;
  assign upd_ataken = head.ataken;
  assign upd_misp   = head.misp;
  assign upd_hist   = head.hist;

endmodule

// File: tb/tb_exu_brupd_ctl.sv
// Directed self-checking bench for exu_brupd_ctl (DEPTH=4, DCW=8).
module tb_exu_brupd_ctl;

  logic        clk;
  logic        rst_l;
  logic        freeze;
  logic        flush;
  logic        br_valid;
  logic [31:1] br_pc;
  logic [31:1] br_target;
  logic        br_ataken;
  logic        br_misp;
  logic [1:0]  br_hist;
  logic        upd_valid;
  logic        upd_ready;
  logic [31:1] upd_pc;
  logic [31:1] upd_target;
  logic        upd_ataken;
  logic        upd_misp;
  logic [1:0]  upd_hist;
  logic        q_full;
  logic [7:0]  drop_cnt;

  int tests;
  int fails;

  exu_brupd_ctl #(.DEPTH(4), .DCW(8)) dut (
    .clk        (clk),
    .rst_l      (rst_l),
    .freeze     (freeze),
    .flush      (flush),
    .br_valid   (br_valid),
    .br_pc      (br_pc),
    .br_target  (br_target),
    .br_ataken  (br_ataken),
    .br_misp    (br_misp),
    .br_hist    (br_hist),
    .upd_valid  (upd_valid),
    .upd_ready  (upd_ready),
    .upd_pc     (upd_pc),
    .upd_target (upd_target),
    .upd_ataken (upd_ataken),
    .upd_misp   (upd_misp),
    .upd_hist   (upd_hist),
    .q_full     (q_full),
    .drop_cnt   (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_br(input logic [31:1] pc, input logic misp);
    br_valid  = 1'b1;
    br_pc     = pc;
    br_target = 31'(pc + 31'h1);
    br_ataken = 1'b1;
    br_misp   = misp;
    br_hist   = 2'b01;
  endtask

  task automatic push(input logic [31:1] pc, input logic misp);
    set_br(pc, misp);
    step();
    br_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_l = 1'b0;
    #2;
    rst_l = 1'b1;
    step();
  endtask

  // Check head pc then pop it
  task automatic pop_expect(input string tag, input logic [31:1] pc);
    upd_ready = 1'b1;
    chk({tag, "_valid"}, 32'(upd_valid), 32'd1);
    chk(tag, 32'(upd_pc), 32'(pc));
    step();
    upd_ready = 1'b0;
  endtask

  initial begin
    tests = 0; fails = 0;
    rst_l = 1'b0; freeze = 1'b0; flush = 1'b0; br_valid = 1'b0;
    br_pc = '0; br_target = '0; br_ataken = 1'b0; br_misp = 1'b0; br_hist = '0;
    upd_ready = 1'b0;
    #12;
    chk("rst_valid", 32'(upd_valid), 32'd0);
    chk("rst_full",  32'(q_full),    32'd0);
    chk("rst_drop",  32'(drop_cnt),  32'd0);
    chk("rst_pc",    32'(upd_pc),    32'd0);
    chk("rst_hist",  32'(upd_hist),  32'd0);
    rst_l = 1'b1;
    step();

    // Single push, held, then popped
    br_valid = 1'b1; br_pc = 31'h100; br_target = 31'h200; br_ataken = 1'b1;
    br_misp = 1'b0; br_hist = 2'b11;
    chk("pre_push_valid", 32'(upd_valid), 32'd0);
    step();
    br_valid = 1'b0;
    chk("single_valid",  32'(upd_valid),  32'd1);
    chk("single_pc",     32'(upd_pc),     32'h100);
    chk("single_target", 32'(upd_target), 32'h200);
    chk("single_ataken", 32'(upd_ataken), 32'd1);
    chk("single_hist",   32'(upd_hist),   32'd3);
    step();
    chk("hold_valid", 32'(upd_valid), 32'd1);
    chk("hold_pc",    32'(upd_pc),    32'h100);
    upd_ready = 1'b1;
    step();
    upd_ready = 1'b0;
    chk("single_popped", 32'(upd_valid), 32'd0);

    // Fill then drop a non-mispredict
    push(31'h10, 1'b0); push(31'h20, 1'b0); push(31'h30, 1'b0);
    chk("three_not_full", 32'(q_full), 32'd0);
    push(31'h40, 1'b0);
    chk("fill_full", 32'(q_full),   32'd1);
    chk("fill_drop", 32'(drop_cnt), 32'd0);
    push(31'h50, 1'b0);
    chk("drop_cnt", 32'(drop_cnt), 32'd1);
    chk("drop_head", 32'(upd_pc), 32'h10);
    chk("drop_full", 32'(q_full), 32'd1);
    pop_expect("drop_q0", 31'h10); pop_expect("drop_q1", 31'h20);
    pop_expect("drop_q2", 31'h30); pop_expect("drop_q3", 31'h40);
    chk("drop_empty", 32'(upd_valid), 32'd0);

    // Mispredict overwrites youngest
    do_reset();
    push(31'hA, 1'b0); push(31'hB, 1'b0); push(31'hC, 1'b0); push(31'hD, 1'b0);
    push(31'hE, 1'b1);
    chk("ow_drop", 32'(drop_cnt), 32'd1);
    chk("ow_full", 32'(q_full),   32'd1);
    chk("ow_head", 32'(upd_pc),   32'hA);
    pop_expect("ow_q0", 31'hA); pop_expect("ow_q1", 31'hB); pop_expect("ow_q2", 31'hC);
    chk("ow_misp",   32'(upd_misp),   32'd1);
    chk("ow_target", 32'(upd_target), 32'hF);
    pop_expect("ow_q3", 31'hE);
    chk("ow_empty", 32'(upd_valid), 32'd0);

    // Full with simultaneous push and pop
    do_reset();
    push(31'hA, 1'b0); push(31'hB, 1'b0); push(31'hC, 1'b0); push(31'hD, 1'b0);
    upd_ready = 1'b1;
    push(31'hF, 1'b0);
    upd_ready = 1'b0;
    chk("pp_full", 32'(q_full),   32'd1);
    chk("pp_drop", 32'(drop_cnt), 32'd0);
    pop_expect("pp_q0", 31'hB); pop_expect("pp_q1", 31'hC);
    pop_expect("pp_q2", 31'hD); pop_expect("pp_q3", 31'hF);
    chk("pp_empty", 32'(upd_valid), 32'd0);

    // Flush and freeze gating
    flush = 1'b1; push(31'h77, 1'b1); flush = 1'b0;
    freeze = 1'b1; push(31'h78, 1'b1); freeze = 1'b0;
    step();
    chk("gate_empty", 32'(upd_valid), 32'd0);
    chk("gate_full",  32'(q_full),    32'd0);
    push(31'h90, 1'b0);
    flush = 1'b1; push(31'h91, 1'b0); flush = 1'b0;
    pop_expect("flush_keep", 31'h90);
    chk("flush_one_entry", 32'(upd_valid), 32'd0);

    // Drop counter saturates
    do_reset();
    push(31'h1, 1'b0); push(31'h2, 1'b0); push(31'h3, 1'b0); push(31'h4, 1'b0);
    set_br(31'h5, 1'b0);
    repeat (260) step();
    br_valid = 1'b0;
    chk("drop_sat", 32'(drop_cnt), 32'hFF);
    chk("sat_head", 32'(upd_pc),   32'h1);

    // Asynchronous reset mid-stream
    do_reset();
    push(31'h31, 1'b0); push(31'h32, 1'b0); push(31'h33, 1'b0);
    set_br(31'h34, 1'b1);
    #2;
    rst_l = 1'b0;
    #1;
    chk("amid_valid", 32'(upd_valid), 32'd0);
    chk("amid_pc",    32'(upd_pc),    32'd0);
    chk("amid_full",  32'(q_full),    32'd0);
    chk("amid_drop",  32'(drop_cnt),  32'd0);
    br_valid = 1'b0;
    rst_l = 1'b1;
    step();
    chk("arel_empty", 32'(upd_valid), 32'd0);

    // Pointer wrap: push/pop pairs
    for (int k = 0; k < 10; k++) begin
      push(31'(32'h400 + 32'(k)), 1'b0);
      pop_expect("wrap", 31'(32'h400 + 32'(k)));
      chk("wrap_empty", 32'(upd_valid), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
